// File: rtl/dp_ram_fifo_pkg.sv
// Shared helpers for the dp_ram FIFO controller and its top-level wrapper.
//   ptr_w(depth)        : pointer width, index bits plus one wrap bit
//   addr_w(base, depth) : RAM address width able to hold base+depth-1
//   DEFAULT_*           : default geometry shared by controller and wrapper
package dp_ram_fifo_pkg;

  localparam int DEFAULT_DATA_WIDTH = 8;
  localparam int DEFAULT_RAM_DEPTH  = 8;
  localparam int DEFAULT_BASE_ADDR  = 0;

  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic int addr_w(input int base, input int depth);
    int w;
    w = $clog2(base + depth);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/dp_ram_fifo_ptr.sv
// Wrap-bit pointer counter used for both the write and the read side.
// Ports:
//   clk, n_rst : clock, asynchronous active-low reset
//   inc        : advance the pointer by one entry
//   clr        : synchronous clear to zero (wins over inc)
//   ptr        : {wrap bit, index}, PTR_W bits
module dp_ram_fifo_ptr
  import dp_ram_fifo_pkg::*;
#(
  parameter  int DEPTH = DEFAULT_RAM_DEPTH,
  localparam int PTR_W = ptr_w(DEPTH)
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             inc,
  input  logic             clr,
  output logic [PTR_W-1:0] ptr
);

  logic [PTR_W-1:0] ptr_q;
  logic [PTR_W-1:0] ptr_d;

  // DEPTH is a power of two, so a plain binary increment wraps the index
  // DEPTH-1 -> 0 and carries into (toggles) the wrap bit.
  always_comb begin
    ptr_d = ptr_q;
    if (clr) begin
      ptr_d = '0;
    end else if (inc) begin
      ptr_d = ptr_q + PTR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr = ptr_q;

endmodule

// File: rtl/dp_ram_fifo_ctrl.sv
// FIFO controller driving a dual-port RAM (sync write port, async read port).
// Upstream is a valid/ready push, downstream a show-ahead valid/ready pop.
// The controller owns pointers, occupancy and flags; the RAM holds payload.
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both 1; valid never depends on ready and ready never depends on valid.
//
// Ports:
//   clk, n_rst              clock, asynchronous active-low reset
//   flush                   synchronous clear of pointers and count
//   in_valid/in_ready/in_data     push side
//   out_valid/out_ready/out_data  pop side, out_data comes straight from RAM
//   count                   registered occupancy 0..RAM_DEPTH
//   ram_wr_en/ram_wr_addr/ram_data_in   RAM write port
//   ram_rd_en/ram_rd_addr/ram_data_out  RAM async read port
//   err_ovf/err_udf         sticky error flags, only when the macro
//                           DP_RAM_FIFO_CTRL_ERR_EN is defined
module dp_ram_fifo_ctrl
  import dp_ram_fifo_pkg::*;
#(
  parameter  int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter  int RAM_DEPTH  = DEFAULT_RAM_DEPTH,
  parameter  int BASE_ADDR  = DEFAULT_BASE_ADDR,
  localparam int PTR_W      = ptr_w(RAM_DEPTH),
  localparam int ADDR_W     = addr_w(BASE_ADDR, RAM_DEPTH)
) (
  input  logic                  clk,
  input  logic                  n_rst,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [PTR_W-1:0]      count,
  output logic                  ram_wr_en,
  output logic [ADDR_W-1:0]     ram_wr_addr,
  output logic [DATA_WIDTH-1:0] ram_data_in,
  output logic                  ram_rd_en,
  output logic [ADDR_W-1:0]     ram_rd_addr,
  input  logic [DATA_WIDTH-1:0] ram_data_out
`ifdef DP_RAM_FIFO_CTRL_ERR_EN
  ,
  output logic                  err_ovf,
  output logic                  err_udf
`endif
);

  localparam int IDX_W = PTR_W - 1;
  localparam logic [ADDR_W-1:0] BASE_A = ADDR_W'(BASE_ADDR);

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] count_q;
  logic [PTR_W-1:0] count_d;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;

  dp_ram_fifo_ptr #(.DEPTH(RAM_DEPTH)) u_wr_ptr (
    .clk   (clk),
    .n_rst (n_rst),
    .inc   (push),
    .clr   (flush),
    .ptr   (wr_ptr)
  );

  dp_ram_fifo_ptr #(.DEPTH(RAM_DEPTH)) u_rd_ptr (
    .clk   (clk),
    .n_rst (n_rst),
    .inc   (pop),
    .clr   (flush),
    .ptr   (rd_ptr)
  );

  // Same index with opposite wrap bits means the writer is a full lap ahead.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[IDX_W-1:0] == rd_ptr[IDX_W-1:0]) &&
                 (wr_ptr[IDX_W] != rd_ptr[IDX_W]);

  // Both ready and valid depend only on state and flush, so a pop cannot
  // open room for a push in the same cycle, and flush drops both transfers.
  assign in_ready  = !full && !flush;
  assign out_valid = !empty && !flush;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // Tracks wr_ptr - rd_ptr without a subtractor on the output path.
  always_comb begin
    count_d = count_q;
    if (flush) begin
      count_d = '0;
    end else if (push && !pop) begin
      count_d = count_q + PTR_W'(1);
    end else if (pop && !push) begin
      count_d = count_q - PTR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count       = count_q;
  assign ram_wr_en   = push;
  assign ram_wr_addr = BASE_A + ADDR_W'(wr_ptr[IDX_W-1:0]);
  assign ram_data_in = in_data;
  assign ram_rd_en   = out_valid;
  assign ram_rd_addr = BASE_A + ADDR_W'(rd_ptr[IDX_W-1:0]);
  assign out_data    = ram_data_out;

`ifdef DP_RAM_FIFO_CTRL_ERR_EN
  logic err_ovf_q;
  logic err_ovf_d;
  logic err_udf_q;
  logic err_udf_d;

  // Flush clears the flags even if an illegal request is seen that cycle.
  always_comb begin
    err_ovf_d = err_ovf_q | (in_valid && full);
    err_udf_d = err_udf_q | (out_ready && empty);
    if (flush) begin
      err_ovf_d = 1'b0;
      err_udf_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      err_ovf_q <= 1'b0;
      err_udf_q <= 1'b0;
    end else begin
      err_ovf_q <= err_ovf_d;
      err_udf_q <= err_udf_d;
    end
  end

  assign err_ovf = err_ovf_q;
  assign err_udf = err_udf_q;
`endif

endmodule

// File: tb/tb_dp_ram_fifo_ctrl.sv
// Bench for dp_ram_fifo_ctrl (DATA_WIDTH=8, RAM_DEPTH=8, BASE_ADDR=0) with a
// behavioural dual-port RAM (sync write, async read). Define
// DP_RAM_FIFO_CTRL_ERR_EN to also exercise the sticky error flags.
module tb_dp_ram_fifo_ctrl;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic n_rst = 1'b0;
  always #5 clk = ~clk;

  logic       flush = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_data = 8'h00;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] out_data;
  logic [3:0] count;
  logic       ram_wr_en;
  logic [2:0] ram_wr_addr;
  logic [7:0] ram_data_in;
  logic       ram_rd_en;
  logic [2:0] ram_rd_addr;
  logic [7:0] ram_data_out;
`ifdef DP_RAM_FIFO_CTRL_ERR_EN
  logic       err_ovf;
  logic       err_udf;
`endif

  dp_ram_fifo_ctrl #(.DATA_WIDTH(8), .RAM_DEPTH(8), .BASE_ADDR(0)) dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .flush        (flush),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .count        (count),
    .ram_wr_en    (ram_wr_en),
    .ram_wr_addr  (ram_wr_addr),
    .ram_data_in  (ram_data_in),
    .ram_rd_en    (ram_rd_en),
    .ram_rd_addr  (ram_rd_addr),
    .ram_data_out (ram_data_out)
`ifdef DP_RAM_FIFO_CTRL_ERR_EN
    ,
    .err_ovf      (err_ovf),
    .err_udf      (err_udf)
`endif
  );

  // ---------------- RAM model ----------------
  logic [7:0] mem [8];
  always @(posedge clk) begin
    if (ram_wr_en) mem[ram_wr_addr] <= ram_data_in;
  end
  assign ram_data_out = mem[ram_rd_addr];

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- vector table ----------------
  // Inputs are applied after a falling edge; expectations describe the
  // outputs before the following rising edge.
  typedef struct {
    logic       in_valid;
    logic       out_ready;
    logic       flush;
    logic [7:0] in_data;
    logic       exp_in_ready;
    logic       exp_out_valid;
    logic       exp_wr_en;
    logic [3:0] exp_count;
    logic       chk_data;
    logic [7:0] exp_data;
    logic [2:0] exp_wr_addr;
    logic [2:0] exp_rd_addr;
  } vec_t;

  vec_t vecs[$];

  task automatic add_vec(input logic iv, input logic ordy, input logic fl, input logic [7:0] d,
                         input logic eir, input logic eov, input logic ewe, input int ecnt,
                         input logic cd, input logic [7:0] ed, input int ewa, input int era);
    vec_t v;
    v.in_valid = iv; v.out_ready = ordy; v.flush = fl; v.in_data = d;
    v.exp_in_ready = eir; v.exp_out_valid = eov; v.exp_wr_en = ewe;
    v.exp_count = 4'(ecnt); v.chk_data = cd; v.exp_data = ed;
    v.exp_wr_addr = 3'(ewa); v.exp_rd_addr = 3'(era);
    vecs.push_back(v);
  endtask

  task automatic build_table();
    // 1: fill with 0x11..0x18, then a blocked push while full
    for (int i = 0; i < 8; i++)
      add_vec(1, 0, 0, 8'(8'h11 + i), 1, (i > 0), 1, i, (i > 0), 8'h11, i, 0);
    add_vec(1, 0, 0, 8'h99, 0, 1, 0, 8, 1, 8'h11, 0, 0);
    // 2: drain 8 in order, then a pop attempt while empty
    for (int j = 0; j < 8; j++)
      add_vec(0, 1, 0, 8'h00, (j > 0), 1, 0, 8 - j, 1, 8'(8'h11 + j), 0, j);
    add_vec(0, 1, 0, 8'h00, 1, 0, 0, 0, 0, 8'h00, 0, 0);
    // 3: prefill 4 (0x20..0x23), stream 20 cycles, drain the last 4
    for (int k = 0; k < 4; k++)
      add_vec(1, 0, 0, 8'(8'h20 + k), 1, (k > 0), 1, k, (k > 0), 8'h20, k, 0);
    for (int s = 0; s < 20; s++)
      add_vec(1, 1, 0, 8'(8'h24 + s), 1, 1, 1, 4, 1, 8'(8'h20 + s), (4 + s) % 8, s % 8);
    for (int d = 0; d < 4; d++)
      add_vec(0, 1, 0, 8'h00, 1, 1, 0, 4 - d, 1, 8'(8'h34 + d), 0, 4 + d);
    // 4: push 0xAA into empty with a simultaneous pop attempt, then pop it
    add_vec(1, 1, 0, 8'hAA, 1, 0, 1, 0, 0, 8'h00, 0, 0);
    add_vec(0, 0, 0, 8'h00, 1, 1, 0, 1, 1, 8'hAA, 1, 0);
    add_vec(0, 1, 0, 8'h00, 1, 1, 0, 1, 1, 8'hAA, 1, 0);
    // 5: store 5 entries, flush with a push and pop request, then idle
    for (int p = 0; p < 5; p++)
      add_vec(1, 0, 0, 8'(8'h51 + p), 1, (p > 0), 1, p, (p > 0), 8'h51, 1 + p, 1);
    add_vec(1, 1, 1, 8'hEE, 0, 0, 0, 5, 0, 8'h00, 6, 1);
    add_vec(0, 0, 0, 8'h00, 1, 0, 0, 0, 0, 8'h00, 0, 0);
  endtask

  task automatic apply_vec(input int idx, input vec_t v);
    @(negedge clk);
    in_valid = v.in_valid; out_ready = v.out_ready; flush = v.flush; in_data = v.in_data;
    #1;
    check($sformatf("v%0d in_ready", idx), 32'(in_ready), 32'(v.exp_in_ready));
    check($sformatf("v%0d out_valid", idx), 32'(out_valid), 32'(v.exp_out_valid));
    check($sformatf("v%0d ram_rd_en", idx), 32'(ram_rd_en), 32'(v.exp_out_valid));
    check($sformatf("v%0d ram_wr_en", idx), 32'(ram_wr_en), 32'(v.exp_wr_en));
    check($sformatf("v%0d count", idx), 32'(count), 32'(v.exp_count));
    check($sformatf("v%0d ram_wr_addr", idx), 32'(ram_wr_addr), 32'(v.exp_wr_addr));
    check($sformatf("v%0d ram_rd_addr", idx), 32'(ram_rd_addr), 32'(v.exp_rd_addr));
    check($sformatf("v%0d ram_data_in", idx), 32'(ram_data_in), 32'(v.in_data));
    if (v.chk_data)
      check($sformatf("v%0d out_data", idx), 32'(out_data), 32'(v.exp_data));
  endtask

  task automatic idle_inputs();
    in_valid = 0; out_ready = 0; flush = 0; in_data = 8'h00;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    build_table();

    // reset state
    repeat (2) @(negedge clk);
    check("rst in_ready", 32'(in_ready), 32'd1);
    check("rst out_valid", 32'(out_valid), 32'd0);
    check("rst count", 32'(count), 32'd0);
    check("rst ram_wr_en", 32'(ram_wr_en), 32'd0);
    check("rst ram_rd_en", 32'(ram_rd_en), 32'd0);
    n_rst = 1'b1;

    foreach (vecs[i]) apply_vec(i, vecs[i]);

    // the flushed push of 0xEE must not have reached the RAM
    check("flush no write", 32'(mem[6] == 8'hEE), 32'd0);

    // reset mid-stream: store 3 entries, then drop n_rst between edges
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_valid = 1; in_data = 8'(8'h61 + i);
    end
    @(negedge clk);
    idle_inputs();
    #1;
    check("pre-rst out_valid", 32'(out_valid), 32'd1);
    check("pre-rst count", 32'(count), 32'd3);
    check("pre-rst out_data", 32'(out_data), 32'h61);
    #2 n_rst = 1'b0;
    #1;
    check("async rst count", 32'(count), 32'd0);
    check("async rst out_valid", 32'(out_valid), 32'd0);
    check("async rst in_ready", 32'(in_ready), 32'd1);
    check("async rst ram_rd_en", 32'(ram_rd_en), 32'd0);
    check("async rst ram_wr_en", 32'(ram_wr_en), 32'd0);
    check("async rst ram_wr_addr", 32'(ram_wr_addr), 32'd0);
    check("async rst ram_rd_addr", 32'(ram_rd_addr), 32'd0);
    @(negedge clk);
    n_rst = 1'b1;

`ifdef DP_RAM_FIFO_CTRL_ERR_EN
    check("err_ovf after reset", 32'(err_ovf), 32'd0);
    check("err_udf after reset", 32'(err_udf), 32'd0);
    for (int i = 0; i < 8; i++) begin
      in_valid = 1; in_data = 8'(8'h71 + i);
      @(negedge clk);
    end
    check("err full count", 32'(count), 32'd8);
    check("err_ovf before ovf", 32'(err_ovf), 32'd0);
    in_valid = 1; in_data = 8'hFF;   // push while full
    @(negedge clk);
    idle_inputs();
    #1;
    check("err_ovf set", 32'(err_ovf), 32'd1);
    check("err_udf not set", 32'(err_udf), 32'd0);
    @(negedge clk);
    check("err_ovf sticky", 32'(err_ovf), 32'd1);
    flush = 1;
    @(negedge clk);
    flush = 0;
    #1;
    check("err_ovf flushed", 32'(err_ovf), 32'd0);
    check("err flush count", 32'(count), 32'd0);
    out_ready = 1;                    // pop while empty
    @(negedge clk);
    out_ready = 0;
    #1;
    check("err_udf set", 32'(err_udf), 32'd1);
    @(negedge clk);
    check("err_udf sticky", 32'(err_udf), 32'd1);
    flush = 1;
    @(negedge clk);
    flush = 0;
    #1;
    check("err_udf flushed", 32'(err_udf), 32'd0);
    check("err_ovf still clear", 32'(err_ovf), 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
